// File: rtl/uart_tx_engine.sv
// UART transmitter: frames one byte per valid/ready handshake as start, data (LSB first),
// optional parity and stop bits on a registered, idle-high serial line.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       transmitting,
  output logic       transmitted,
  output logic       baud_tick
);

  localparam int         CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             parity_bit;
  logic             accept;

  // Ready depends only on state, so there is no combinational path from tx_valid.
  assign tx_ready     = (state == S_IDLE);
  assign transmitting = (state != S_IDLE);
  assign baud_tick    = (state != S_IDLE) && (clk_cnt == CNT_LAST);
  assign accept       = tx_valid & tx_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the async reset branch forces the line high immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      parity_bit  <= 1'b0;
      tx          <= 1'b1;
      transmitted <= 1'b0;
    end else begin
      transmitted <= 1'b0;

      if (state == S_IDLE || baud_tick) clk_cnt <= '0;
      else                              clk_cnt <= clk_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          bit_idx <= '0;
          if (accept) begin
            shift      <= tx_data;
            parity_bit <= (^(tx_data & DATA_MASK)) ^ (PARITY_ODD != 0);
            tx         <= 1'b0;
            state      <= S_START;
          end
        end
        S_START: begin
          if (baud_tick) begin
            tx    <= shift[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            shift <= shift >> 1;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx     <= '0;
              transmitted <= 1'b1;
              state       <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
